uart_top: RTL and testbench

// - 8N1 UART transceiver: transmitter and receiver sharing one system clock.
// - The TX path serialises tx_data_i on txd_o; the RX path deserialises rxd_i into rx_data_o.
// - TX and RX are independent, so txd_o may be looped back to rxd_i for self-test.
// - Sits between a byte-wide host interface and the external serial pins.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx.sv | 102 ++++++++++
 rtl/uart_tx.sv | 98 +++++++++
 rtl/uart_top.sv | 42 ++++
 tb/tb_uart_top.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART transceiver.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Number of system clocks per serial bit (integer division, truncating).
  function automatic int clks_per_bit(input int sys_frequency, input int baud_rate);
    return sys_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 deserialiser with mid-bit sampling and start-glitch / framing rejection.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd_i,
  output logic       rx_done,
  output logic [7:0] rx_data_o
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_MAX = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t      state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [2:0]     bit_reg;
  logic [7:0]     shift_reg;
  logic [7:0]     data_reg;
  logic           done_reg;
  logic           sync1_reg;
  logic           sync2_reg;

  logic bit_end;
  assign bit_end = (cnt_reg == CNT_MAX);

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= rxd_i;
      sync2_reg <= sync1_reg;
    end
  end

  // Receive sequencer: half a bit into START, then whole bits, lands mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RX_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RX_IDLE: begin
          cnt_reg <= '0;
          if (!sync2_reg) begin
            done_reg  <= 1'b0;
            state_reg <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_reg == HALF_MAX) begin
            cnt_reg   <= '0;
            bit_reg   <= '0;
            state_reg <= sync2_reg ? RX_IDLE : RX_DATA;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        RX_DATA: begin
          if (bit_end) begin
            cnt_reg   <= '0;
            shift_reg <= {sync2_reg, shift_reg[7:1]};
            if (bit_reg == 3'd7) begin
              state_reg <= RX_STOP;
            end else begin
              bit_reg <= bit_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        RX_STOP: begin
          if (bit_end) begin
            cnt_reg   <= '0;
            state_reg <= RX_IDLE;
            // A low stop bit is a framing error: drop the byte silently.
            if (sync2_reg) begin
              data_reg <= shift_reg;
              done_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: state_reg <= RX_IDLE;
      endcase
    end
  end

  assign rx_done   = done_reg;
  assign rx_data_o = data_reg;

endmodule

// File: rtl/uart_tx.sv
// 8N1 serialiser: one frame per rising edge of new_data seen while idle.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data_i,
  input  logic       new_data,
  output logic       txd_o,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  tx_state_t      state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [2:0]     bit_reg;
  logic [7:0]     shift_reg;
  logic           nd_reg;
  logic           txd_reg;
  logic           done_reg;

  logic start_req;
  logic bit_end;

  // Only a fresh 0->1 transition counts; a level held high never restarts a frame.
  assign start_req = new_data & ~nd_reg;
  assign bit_end   = (cnt_reg == CNT_MAX);

  // Frame sequencer: line level is registered so txd_o is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= TX_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      nd_reg    <= 1'b0;
      txd_reg   <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      nd_reg <= new_data;
      case (state_reg)
        TX_IDLE: begin
          cnt_reg <= '0;
          if (start_req) begin
            shift_reg <= tx_data_i;
            done_reg  <= 1'b0;
            txd_reg   <= 1'b0;
            state_reg <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            cnt_reg   <= '0;
            bit_reg   <= '0;
            txd_reg   <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state_reg <= TX_DATA;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            cnt_reg <= '0;
            if (bit_reg == 3'd7) begin
              txd_reg   <= 1'b1;
              state_reg <= TX_STOP;
            end else begin
              bit_reg   <= bit_reg + 3'd1;
              txd_reg   <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            cnt_reg   <= '0;
            done_reg  <= 1'b1;
            state_reg <= TX_IDLE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: state_reg <= TX_IDLE;
      endcase
    end
  end

  assign txd_o   = txd_reg;
  assign tx_done = done_reg;

endmodule

// File: rtl/uart_top.sv
// 8N1 UART transceiver: independent TX and RX paths on one system clock.
module uart_top
  import uart_pkg::*;
#(
  parameter int BAUD_RATE     = 9600,
  parameter int SYS_FREQUENCY = 1000000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [7:0] tx_data_i,
  input  logic       new_data,
  output logic       txd_o,
  output logic       tx_done,
  input  logic       rxd_i,
  output logic       rx_done,
  output logic [7:0] rx_data_o
);

  localparam int CLKS_PER_BIT = clks_per_bit(SYS_FREQUENCY, BAUD_RATE);

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk       (sys_clk),
    .rst_n     (reset),
    .tx_data_i (tx_data_i),
    .new_data  (new_data),
    .txd_o     (txd_o),
    .tx_done   (tx_done)
  );

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (sys_clk),
    .rst_n     (reset),
    .rxd_i     (rxd_i),
    .rx_done   (rx_done),
    .rx_data_o (rx_data_o)
  );

endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top: loopback scoreboard, TX bit timing, edge rules,
// direct RX framing/glitch cases and mid-frame reset.
module tb_uart_top;

  localparam int CPB = 104;

  logic       sys_clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data_i = 8'h00;
  logic       new_data = 1'b0;
  logic       txd_o;
  logic       tx_done;
  logic       rxd_i;
  logic       rx_done;
  logic [7:0] rx_data_o;

  logic loopback = 1'b1;
  logic rxd_drv = 1'b1;
  assign rxd_i = loopback ? txd_o : rxd_drv;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  uart_top #(
    .BAUD_RATE(9600),
    .SYS_FREQUENCY(1000000)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .tx_data_i (tx_data_i),
    .new_data  (new_data),
    .txd_o     (txd_o),
    .tx_done   (tx_done),
    .rxd_i     (rxd_i),
    .rx_done   (rx_done),
    .rx_data_o (rx_data_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance n clocks and settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 3000; k++) begin
      if (tx_done === 1'b1 && rx_done === 1'b1) break;
      tick(1);
    end
    check(tag, {30'd0, tx_done, rx_done}, 32'd3);
  endtask

  task automatic send_lb(input logic [7:0] b);
    sb_q.push_back(b);
    tx_data_i = b;
    new_data  = 1'b1;
    tick(110);
    new_data = 1'b0;
    wait_done($sformatf("lb_done_%02h", b));
    tick(5);
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = fr[i];
      tick(CPB);
    end
    rxd_drv = 1'b1;
  endtask

  // Scoreboard consumer: every rx_done rising edge pops one expected byte.
  logic rx_done_prev = 1'b0;
  always @(negedge sys_clk) begin
    if (rx_done === 1'b1 && rx_done_prev !== 1'b1) begin
      if (sb_q.size() == 0) check("rx_unexpected_frame", sb_q.size(), 1);
      else check("rx_byte", {24'd0, rx_data_o}, {24'd0, sb_q.pop_front()});
    end
    rx_done_prev <= rx_done;
  end

  initial begin
    logic [9:0] frame;
    int lat;
    int cnt;
    logic prev;

    // Reset state
    tick(20);
    check("rst_txd", txd_o, 1);
    check("rst_tx_done", tx_done, 0);
    check("rst_rx_done", rx_done, 0);
    check("rst_rx_data", rx_data_o, 0);
    reset = 1'b1;
    tick(5);

    // Loopback of five patterns
    send_lb(8'hA5);
    send_lb(8'h5A);
    send_lb(8'hFF);
    send_lb(8'h00);
    send_lb(8'hC3);

    // TX timing for A5
    frame = {1'b1, 8'hA5, 1'b0};
    sb_q.push_back(8'hA5);
    tx_data_i = 8'hA5;
    new_data  = 1'b1;
    lat = 1;
    for (lat = 1; lat <= 5; lat++) begin
      tick(1);
      if (txd_o === 1'b0) break;
    end
    check("tx_start_latency_1_to_2", {31'd0, (lat >= 1 && lat <= 2)}, 1);
    for (int off = 0; off <= 10 * CPB; off++) begin
      if (off == 110) new_data = 1'b0;
      if (off < 10 * CPB && (off % CPB == 0 || off % CPB == CPB - 1))
        check($sformatf("tx_bit%0d_off%0d", off / CPB, off), txd_o, frame[off / CPB]);
      if (off == 10 * CPB - 1) check("tx_done_before_1040", tx_done, 0);
      if (off == 10 * CPB) check("tx_done_at_1040", tx_done, 1);
      if (off < 10 * CPB) tick(1);
    end
    tick(20);

    // new_data held high: one frame only
    sb_q.push_back(8'h96);
    tx_data_i = 8'h96;
    new_data  = 1'b1;
    cnt  = 0;
    prev = tx_done;
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if (tx_done === 1'b1 && prev !== 1'b1) cnt++;
      prev = tx_done;
    end
    new_data = 1'b0;
    check("held_high_one_frame", cnt, 1);
    tick(5);

    // Second rising edge during a frame is ignored
    sb_q.push_back(8'h69);
    tx_data_i = 8'h69;
    new_data  = 1'b1;
    cnt  = 0;
    prev = tx_done;
    for (int i = 0; i < 2500; i++) begin
      if (i == 50) new_data = 1'b0;
      if (i == 300) begin
        new_data  = 1'b1;
        tx_data_i = 8'h00;
      end
      if (i == 400) new_data = 1'b0;
      tick(1);
      if (tx_done === 1'b1 && prev !== 1'b1) cnt++;
      prev = tx_done;
    end
    check("midframe_edge_one_frame", cnt, 1);

    // Direct RX: valid frame, then framing error with 3C
    loopback = 1'b0;
    rxd_drv  = 1'b1;
    tick(10);
    sb_q.push_back(8'h81);
    drive_rx(8'h81, 1'b1);
    tick(60);
    check("rx_direct_done", rx_done, 1);
    drive_rx(8'h3C, 1'b0);
    tick(200);
    check("framing_rx_done", rx_done, 0);
    check("framing_rx_data", rx_data_o, 8'h81);

    // Glitch after a good frame
    sb_q.push_back(8'h42);
    drive_rx(8'h42, 1'b1);
    tick(60);
    check("rx_direct_done2", rx_done, 1);
    rxd_drv = 1'b0;
    tick(30);
    rxd_drv = 1'b1;
    tick(300);
    check("glitch_rx_done", rx_done, 0);
    check("glitch_rx_data", rx_data_o, 8'h42);
    sb_q.push_back(8'h5A);
    drive_rx(8'h5A, 1'b1);
    tick(60);
    check("after_glitch_rx_done", rx_done, 1);

    // Reset in the middle of a TX frame
    loopback = 1'b1;
    tick(5);
    tx_data_i = 8'hA5;
    new_data  = 1'b1;
    tick(500);
    reset = 1'b0;
    #1;
    check("midrst_txd", txd_o, 1);
    check("midrst_tx_done", tx_done, 0);
    check("midrst_rx_done", rx_done, 0);
    check("midrst_rx_data", rx_data_o, 0);
    new_data = 1'b0;
    tick(20);
    reset = 1'b1;
    tick(10);
    send_lb(8'hA5);

    tick(20);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
